// File: rtl/sound_rom_scheduler_if.sv
// Avalon-MM read port bundle between the sound scheduler and the shared sample ROM.
// master = scheduler side, slave = ROM side.
interface sound_rom_scheduler_if;
    logic [16:0] rom_addr;
    logic        rom_read;
    logic [3:0]  rom_burstcount;
    logic        rom_waitrequest;
    logic [31:0] rom_readdata;
    logic        rom_readdatavalid;

    modport master (
        output rom_addr, rom_read, rom_burstcount,
        input  rom_waitrequest, rom_readdata, rom_readdatavalid
    );

    modport slave (
        input  rom_addr, rom_read, rom_burstcount,
        output rom_waitrequest, rom_readdata, rom_readdatavalid
    );
endinterface

// File: rtl/sound_rom_scheduler.sv
// Time-shares one 32-bit sample ROM between NUM_CH sound channels and mixes one sample per period.
// Define SOUND_MIX_SAT_EN to clamp the mix; otherwise the sum is attenuated by $clog2(NUM_CH).
module sound_rom_scheduler #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned SAMPLE_DIV = 1250
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [NUM_CH-1:0]     trigger,
    input  logic [NUM_CH-1:0]     stop,
    input  logic [NUM_CH*17-1:0]  ch_offset,
    input  logic [NUM_CH*18-1:0]  ch_depth,
    input  logic [NUM_CH*8-1:0]   ch_repeats,
    output logic [NUM_CH-1:0]     active,
    sound_rom_scheduler_if.master rom,
    output logic [15:0]           mix_out,
    output logic                  mix_valid,
    output logic                  overrun
);

    localparam int unsigned ChW  = $clog2(NUM_CH + 1);
    localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [2:0] {StIdle, StScan, StIssue, StWait, StOut} state_e;

    state_e             state_q, state_d;
    logic [DivW-1:0]    div_q;
    logic               tick;
    logic [ChW-1:0]     ch_q;
    logic signed [19:0] acc_q, acc_sum;
    logic               half_q;
    logic [17:0]        idx_q [NUM_CH];
    logic [7:0]         rem_q [NUM_CH];
    logic [NUM_CH-1:0]  active_q;
    logic [15:0]        mix_q, mix_d;
    logic               overrun_q;
    logic [16:0]        sel_offset;
    logic [17:0]        sel_depth, sel_idx;
    logic               sel_active;
    logic [15:0]        sample;
    logic               scan_done;
    logic               rom_read_d;
    logic [16:0]        rom_addr_d;

    assign tick      = (div_q == DivW'(SAMPLE_DIV - 1));
    assign scan_done = (ch_q == ChW'(NUM_CH));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DivW'(1);
        end
    end

    // Per-channel view of the channel currently being scanned.
    always_comb begin
        sel_offset = '0;
        sel_depth  = '0;
        sel_idx    = '0;
        sel_active = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == ChW'(i)) begin
                sel_offset = ch_offset[i*17 +: 17];
                sel_depth  = ch_depth[i*18 +: 18];
                sel_idx    = idx_q[i];
                sel_active = active_q[i];
            end
        end
    end

    assign sample  = half_q ? rom.rom_readdata[15:0] : rom.rom_readdata[31:16];
    assign acc_sum = acc_q + {{4{sample[15]}}, sample};

`ifdef SOUND_MIX_SAT_EN
    always_comb begin
        if (acc_q > 20'sd32767) begin
            mix_d = 16'h7FFF;
        end else if (acc_q < -20'sd32768) begin
            mix_d = 16'h8000;
        end else begin
            mix_d = acc_q[15:0];
        end
    end
`else
    localparam int unsigned Shift = $clog2(NUM_CH);
    assign mix_d = 16'(acc_q >>> Shift);
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_read_d = 1'b0;
        rom_addr_d = '0;
        mix_valid  = 1'b0;
        unique case (state_q)
            StIdle:  if (tick) state_d = StScan;
            StScan: begin
                if (scan_done) begin
                    state_d = StOut;
                end else if (sel_active) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                rom_read_d = 1'b1;
                rom_addr_d = sel_offset + sel_idx[17:1];
                if (!rom.rom_waitrequest) state_d = StWait;
            end
            StWait:  if (rom.rom_readdatavalid) state_d = StScan;
            StOut: begin
                mix_valid = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rom.rom_read       = rom_read_d;
    assign rom.rom_addr       = rom_addr_d;
    assign rom.rom_burstcount = {3'b000, rom_read_d};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ch_q      <= '0;
            acc_q     <= '0;
            half_q    <= 1'b0;
            active_q  <= '0;
            mix_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                idx_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            if (tick && state_q != StIdle) overrun_q <= 1'b1;

            case (state_q)
                StIdle: begin
                    if (tick) begin
                        acc_q <= '0;
                        ch_q  <= '0;
                    end
                end
                StScan: begin
                    if (scan_done) begin
                        mix_q <= mix_d;
                    end else if (!sel_active) begin
                        ch_q <= ch_q + ChW'(1);
                    end
                end
                // Latch the half select so a restart mid-fetch cannot change which half is summed.
                StIssue: if (!rom.rom_waitrequest) half_q <= sel_idx[0];
                StWait: begin
                    if (rom.rom_readdatavalid) begin
                        acc_q <= acc_sum;
                        ch_q  <= ch_q + ChW'(1);
                    end
                end
                default: ;
            endcase

            // Later assignments win: advance, then stop, then trigger.
            for (int i = 0; i < NUM_CH; i++) begin
                if (state_q == StWait && rom.rom_readdatavalid && ch_q == ChW'(i)) begin
                    if (idx_q[i] == ch_depth[i*18 +: 18] - 18'd1) begin
                        idx_q[i] <= '0;
                        if (rem_q[i] == 8'd1) begin
                            active_q[i] <= 1'b0;
                        end else if (rem_q[i] != 8'd0) begin
                            rem_q[i] <= rem_q[i] - 8'd1;
                        end
                    end else begin
                        idx_q[i] <= idx_q[i] + 18'd1;
                    end
                end
                if (stop[i]) active_q[i] <= 1'b0;
                if (trigger[i] && ch_depth[i*18 +: 18] != 18'd0) begin
                    idx_q[i]    <= '0;
                    rem_q[i]    <= ch_repeats[i*8 +: 8];
                    active_q[i] <= 1'b1;
                end
            end
        end
    end

    assign active  = active_q;
    assign mix_out = mix_q;
    assign overrun = overrun_q;

    // sel_depth is kept for visibility of the scanned channel's length in waveforms.
    logic unused_sel_depth;
    assign unused_sel_depth = ^sel_depth;

endmodule

// File: tb/tb_sound_rom_scheduler.sv
// Scoreboard bench for sound_rom_scheduler: a ROM responder checks addresses from a queue,
// and each mixed sample is checked against a queue of expected values.
module tb_sound_rom_scheduler;

    localparam int unsigned NumCh     = 4;
    localparam int unsigned SampleDiv = 24;

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  trigger;
    logic [3:0]  stop;
    logic [67:0] ch_offset;
    logic [71:0] ch_depth;
    logic [31:0] ch_repeats;
    logic [3:0]  active;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic        overrun;

    sound_rom_scheduler_if rom_bus ();

    sound_rom_scheduler #(
        .NUM_CH     (NumCh),
        .SAMPLE_DIV (SampleDiv)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .trigger    (trigger),
        .stop       (stop),
        .ch_offset  (ch_offset),
        .ch_depth   (ch_depth),
        .ch_repeats (ch_repeats),
        .active     (active),
        .rom        (rom_bus),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_cycles = 0;
    int cur_stall = 0;
    int stall_total = 0;
    logic [16:0] addr_q[$];
    logic [15:0] mix_exp_q[$];
    logic        rvalid_r = 1'b0;
    logic [31:0] rdata_r = '0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_mix(input int acc);
        int s;
`ifdef SOUND_MIX_SAT_EN
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        s = acc;
`else
        s = acc >>> 2;
`endif
        return s[15:0];
    endfunction

    function automatic logic [31:0] rom_word(input logic [16:0] a);
        case (a)
            17'd35729: return 32'h0001_0002;
            17'd35730: return 32'h0003_0004;
            17'd100:   return 32'h7000_0000;
            17'd200:   return 32'h7000_0000;
            17'd300:   return 32'h0100_0200;
            17'd301:   return 32'h0300_0000;
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    assign rom_bus.rom_waitrequest   = (cur_stall < stall_cycles);
    assign rom_bus.rom_readdata      = rdata_r;
    assign rom_bus.rom_readdatavalid = rvalid_r;

    // ROM responder: stalls each read stall_cycles cycles, answers one cycle after acceptance.
    always @(posedge clk) begin
        logic [16:0] a;
        rvalid_r <= 1'b0;
        if (rom_bus.rom_read) begin
            if (cur_stall < stall_cycles) begin
                cur_stall   <= cur_stall + 1;
                stall_total <= stall_total + 1;
                if (addr_q.size() > 0) begin
                    check_value("stall_addr", 32'(rom_bus.rom_addr), 32'(addr_q[0]));
                end
            end else begin
                cur_stall <= 0;
                check_value("burstcount", 32'(rom_bus.rom_burstcount), 32'd1);
                if (addr_q.size() == 0) begin
                    check_value("rom_extra_read", 32'(rom_bus.rom_addr), 32'hFFFF_FFFF);
                end else begin
                    a = addr_q.pop_front();
                    check_value("rom_addr", 32'(rom_bus.rom_addr), 32'(a));
                end
                rdata_r  <= rom_word(rom_bus.rom_addr);
                rvalid_r <= 1'b1;
            end
        end
    end

    task automatic collect_mix(input string tag, output int lat);
        int n = 0;
        logic [15:0] e;
        do begin
            @(negedge clk);
            n++;
        end while (!mix_valid && n < 500);
        lat = n;
        if (!mix_valid) begin
            check_value({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (mix_exp_q.size() == 0) begin
            check_value({tag, "_extra"}, 32'(mix_out), 32'hFFFF_FFFF);
        end else begin
            e = mix_exp_q.pop_front();
            check_value(tag, 32'(mix_out), 32'(e));
        end
    endtask

    task automatic wait_read(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rom_bus.rom_read && n < 500);
        if (!rom_bus.rom_read) check_value({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse(input logic [3:0] t, input logic [3:0] s);
        trigger = t;
        stop    = s;
        @(negedge clk);
        trigger = '0;
        stop    = '0;
    endtask

    task automatic set_ch(input int i, input logic [16:0] off, input logic [17:0] dep,
                          input logic [7:0] rep);
        ch_offset[i*17 +: 17] = off;
        ch_depth[i*18 +: 18]  = dep;
        ch_repeats[i*8 +: 8]  = rep;
    endtask

    initial begin
        int lat;
        int prev;
        int s0;
        resetN     = 1'b0;
        trigger    = '0;
        stop       = '0;
        ch_offset  = '0;
        ch_depth   = '0;
        ch_repeats = '0;
        repeat (3) @(negedge clk);

        check_value("rst_active", 32'(active), 32'd0);
        check_value("rst_mix_out", 32'(mix_out), 32'd0);
        check_value("rst_mix_valid", 32'(mix_valid), 32'd0);
        check_value("rst_overrun", 32'(overrun), 32'd0);
        check_value("rst_rom_read", 32'(rom_bus.rom_read), 32'd0);
        check_value("rst_rom_addr", 32'(rom_bus.rom_addr), 32'd0);
        check_value("rst_burstcount", 32'(rom_bus.rom_burstcount), 32'd0);

        // Idle period: silent mix, 2+NUM_CH cycles after the first tick
        mix_exp_q.push_back(16'h0000);
        resetN = 1'b1;
        collect_mix("idle_mix", lat);
        check_value("idle_latency", 32'(lat), 32'(SampleDiv + 5));

        // Two plays of a 4-sample clip
        set_ch(0, 17'd35729, 18'd4, 8'd2);
        for (int p = 0; p < 2; p++) begin
            addr_q.push_back(17'd35729);
            addr_q.push_back(17'd35729);
            addr_q.push_back(17'd35730);
            addr_q.push_back(17'd35730);
            for (int k = 1; k <= 4; k++) mix_exp_q.push_back(exp_mix(k));
        end
        pulse(4'b0001, 4'b0000);
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            collect_mix("t1_mix", lat);
            check_value("t1_active", 32'(active[0]), (i < 7) ? 32'd1 : 32'd0);
            if (i > 0) check_value("t1_period", 32'(cyc - prev), 32'(SampleDiv));
            prev = cyc;
        end
        mix_exp_q.push_back(16'h0000);
        collect_mix("t1_silent", lat);
        check_value("t1_addr_left", 32'(addr_q.size()), 32'd0);

        // Stalled read with a stop arriving during the stall
        s0 = stall_total;
        stall_cycles = 5;
        set_ch(0, 17'd35729, 18'd4, 8'd1);
        addr_q.push_back(17'd35729);
        mix_exp_q.push_back(exp_mix(1));
        pulse(4'b0001, 4'b0000);
        wait_read("t2_read");
        pulse(4'b0000, 4'b0001);
        collect_mix("t2_mix", lat);
        check_value("t2_stalls", 32'(stall_total - s0), 32'd5);
        check_value("t2_active", 32'(active[0]), 32'd0);
        stall_cycles = 0;
        mix_exp_q.push_back(16'h0000);
        collect_mix("t2_after_stop", lat);

        // Two channels summed, scan order ch0 then ch2
        set_ch(0, 17'd100, 18'd2, 8'd1);
        set_ch(2, 17'd200, 18'd2, 8'd1);
        addr_q.push_back(17'd100);
        addr_q.push_back(17'd200);
        mix_exp_q.push_back(exp_mix(2 * 28672));
        pulse(4'b0101, 4'b0000);
        collect_mix("t3_mix", lat);
        check_value("t3_active", 32'(active), 32'b0101);
        pulse(4'b0000, 4'b0101);

        // Endless loop of a 3-sample clip, then stop+trigger together
        set_ch(1, 17'd300, 18'd3, 8'd0);
        for (int i = 0; i < 20; i++) begin
            addr_q.push_back((i % 3 == 2) ? 17'd301 : 17'd300);
            mix_exp_q.push_back(exp_mix(256 * (i % 3 + 1)));
        end
        pulse(4'b0010, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            collect_mix("t4_loop_mix", lat);
            check_value("t4_active", 32'(active[1]), 32'd1);
        end
        addr_q.push_back(17'd300);
        addr_q.push_back(17'd300);
        mix_exp_q.push_back(exp_mix(256));
        mix_exp_q.push_back(exp_mix(512));
        pulse(4'b0010, 4'b0010);
        collect_mix("t4_restart_mix", lat);
        collect_mix("t4_restart_mix", lat);
        check_value("t4_active_after", 32'(active[1]), 32'd1);
        pulse(4'b0000, 4'b0010);
        check_value("t4_no_overrun", 32'(overrun), 32'd0);

        // Zero-length clip is ignored
        set_ch(3, 17'd400, 18'd0, 8'd1);
        pulse(4'b1000, 4'b0000);
        check_value("t6_active_now", 32'(active[3]), 32'd0);
        mix_exp_q.push_back(16'h0000);
        collect_mix("t6_mix", lat);
        check_value("t6_active", 32'(active), 32'd0);

        // Stall longer than a sample period: overrun, dropped ticks, then reset mid-WAIT
        set_ch(0, 17'd35729, 18'd4, 8'd0);
        stall_cycles = 40;
        addr_q.push_back(17'd35729);
        mix_exp_q.push_back(exp_mix(1));
        pulse(4'b0001, 4'b0000);
        collect_mix("t5_mix", lat);
        prev = cyc;
        check_value("t5_overrun", 32'(overrun), 32'd1);
        stall_cycles = 0;
        addr_q.push_back(17'd35729);
        mix_exp_q.push_back(exp_mix(2));
        collect_mix("t5_next_mix", lat);
        check_value("t5_dropped_tick_gap", 32'(cyc - prev), 32'(2 * SampleDiv - 16));
        addr_q.push_back(17'd35730);
        wait_read("t5_read");
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check_value("t5_rst_rom_read", 32'(rom_bus.rom_read), 32'd0);
        check_value("t5_rst_active", 32'(active), 32'd0);
        check_value("t5_rst_mix_out", 32'(mix_out), 32'd0);
        check_value("t5_rst_overrun", 32'(overrun), 32'd0);
        check_value("t5_rst_mix_valid", 32'(mix_valid), 32'd0);
        check_value("t5_rst_rom_addr", 32'(rom_bus.rom_addr), 32'd0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        mix_exp_q.push_back(16'h0000);
        collect_mix("t5_post_reset_mix", lat);
        check_value("t5_addr_left", 32'(addr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
